// File: rtl/pe_blk_feeder_pkg.sv
// pe_blk_feeder_pkg
// Shared definitions for the PE block feeder:
//   - PE data-sharing mode encodings (PE_SHARE_NONE .. PE_SHARE_ALL)
//   - feeder FSM state encoding
//   - flush_len(): zero rows needed to drain every partial sum out of a
//     systolic block of the given depth and column count
package pe_blk_feeder_pkg;

  localparam logic [2:0] PE_SHARE_NONE = 3'b000;
  localparam logic [2:0] PE_SHARE_ROW  = 3'b001;
  localparam logic [2:0] PE_SHARE_COL  = 3'b010;
  localparam logic [2:0] PE_SHARE_BLK  = 3'b011;
  localparam logic [2:0] PE_SHARE_ALL  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_WT = 2'd1,
    ST_STREAM  = 2'd2,
    ST_FLUSH   = 2'd3
  } feeder_state_e;

  function automatic int unsigned flush_len(input int unsigned depth,
                                            input int unsigned column);
    return depth + column - 1;
  endfunction

endpackage

// File: rtl/pe_blk_feeder_skew_lane_delay.sv
// skew_lane_delay
// Fixed-length register delay line used to build the diagonal activation
// skew. Each lane gets its own instance with a different number of stages.
// Ports:
//   clk, reset   clock, synchronous active-high clear of every stage
//   din          value entering the line this cycle
//   dout         value that entered delay_stages cycles ago
module skew_lane_delay #(
  parameter int unsigned delay_stages = 1,
  parameter int unsigned width        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] stage_q [delay_stages];
  logic [width-1:0] stage_d [delay_stages];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < int'(delay_stages); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(delay_stages); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(delay_stages); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[delay_stages-1];

endmodule

// File: rtl/pe_blk_feeder.sv
// pe_blk_feeder
// Transmit-side sequencer for the PE block array. Loads systolic_depth
// weight rows (first beat = deepest array row), then streams activation
// rows with a diagonal skew, then injects zero rows until every partial
// sum has drained, and pulses done.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wt_valid/ready/data   weight row stream (one row for all blocks)
//   act_valid/ready/data  activation row stream, act_last marks the final beat
//   is_wt, wt_in          registered weight-load strobe and row to the array
//   data_in               skewed activations to the array
//   busy                  high whenever the FSM is not IDLE
//   done                  one-cycle pulse at the end of the flush
//   dbg_state             current FSM state (feeder_state_e encoding)
//
// Handshake: a beat transfers on a rising edge where valid && ready are
// both high. ready depends only on the current state, never on valid, so a
// source may hold valid high indefinitely; a beat offered while ready is
// low is simply not taken.
module pe_blk_feeder
  import pe_blk_feeder_pkg::*;
#(
  parameter int unsigned bit_width       = 8,
  parameter int unsigned systolic_depth  = 4,
  parameter int unsigned systolic_column = 16,
  parameter int unsigned pe_blk_count    = 16,
  parameter logic [2:0]  mode            = PE_SHARE_ALL,
  parameter int unsigned cnt_width       = 8
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             wt_valid,
  output logic                                             wt_ready,
  input  logic [bit_width*systolic_column*pe_blk_count-1:0] wt_data,
  input  logic                                             act_valid,
  output logic                                             act_ready,
  input  logic [bit_width*systolic_depth*pe_blk_count-1:0]  act_data,
  input  logic                                             act_last,
  output logic                                             is_wt,
  output logic [bit_width*systolic_column*pe_blk_count-1:0] wt_in,
  output logic [bit_width*systolic_depth*pe_blk_count-1:0]  data_in,
  output logic                                             busy,
  output logic                                             done,
  output logic [1:0]                                       dbg_state
);

  localparam int unsigned WT_W  = bit_width * systolic_column * pe_blk_count;
  localparam int unsigned ROW_W = bit_width * systolic_depth;
  localparam int unsigned ACT_W = ROW_W * pe_blk_count;

  localparam logic [cnt_width-1:0] WT_LAST    = cnt_width'(systolic_depth - 1);
  // flush_cnt runs 0..FLUSH_LEN-1 injecting zeros, then FLUSH_LEN is the
  // done cycle, still inside FLUSH so busy only drops afterwards.
  localparam logic [cnt_width-1:0] FLUSH_ZERO_LAST =
    cnt_width'(flush_len(systolic_depth, systolic_column) - 1);
  localparam logic [cnt_width-1:0] FLUSH_DONE =
    cnt_width'(flush_len(systolic_depth, systolic_column));

  feeder_state_e          state_q, state_d;
  logic [cnt_width-1:0]   wt_cnt_q, wt_cnt_d;
  logic [cnt_width-1:0]   flush_cnt_q, flush_cnt_d;
  logic                   is_wt_q, is_wt_d;
  logic [WT_W-1:0]        wt_in_q, wt_in_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic wt_accept;
  logic act_accept;

  assign wt_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD_WT);
  assign act_ready  = (state_q == ST_STREAM);
  assign wt_accept  = wt_valid && wt_ready;
  assign act_accept = act_valid && act_ready;

  always_comb begin
    state_d     = state_q;
    wt_cnt_d    = wt_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wt_accept) begin
          if (WT_LAST == '0) begin
            state_d  = ST_STREAM;
            wt_cnt_d = '0;
          end else begin
            state_d  = ST_LOAD_WT;
            wt_cnt_d = cnt_width'(1);
          end
        end
      end
      ST_LOAD_WT: begin
        if (wt_accept) begin
          if (wt_cnt_q == WT_LAST) begin
            state_d  = ST_STREAM;
            wt_cnt_d = '0;
          end else begin
            wt_cnt_d = wt_cnt_q + cnt_width'(1);
          end
        end
      end
      ST_STREAM: begin
        if (act_accept && act_last) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_DONE) begin
          state_d     = ST_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + cnt_width'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    is_wt_d = wt_accept;
    wt_in_d = wt_accept ? wt_data : wt_in_q;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_FLUSH) && (flush_cnt_q == FLUSH_ZERO_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wt_cnt_q    <= '0;
      flush_cnt_q <= '0;
      is_wt_q     <= 1'b0;
      wt_in_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wt_cnt_q    <= wt_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      is_wt_q     <= is_wt_d;
      wt_in_q     <= wt_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign is_wt     = is_wt_q;
  assign wt_in     = wt_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

  // Skew pipeline: advances every cycle. A bubble, or any cycle outside an
  // accepted STREAM beat, injects an all-zero row. Lane d uses d+1 stages so
  // it reaches data_in d cycles after lane 0.
  generate
    if (mode == PE_SHARE_ALL) begin : g_bcast
      logic [ROW_W-1:0] inject_row;
      logic [ROW_W-1:0] row_skewed;

      assign inject_row = act_accept ? act_data[ROW_W-1:0] : '0;

      for (genvar d = 0; d < int'(systolic_depth); d++) begin : g_lane
        skew_lane_delay #(
          .delay_stages(d + 1),
          .width       (bit_width)
        ) u_dly (
          .clk  (clk),
          .reset(reset),
          .din  (inject_row[d*bit_width +: bit_width]),
          .dout (row_skewed[d*bit_width +: bit_width])
        );
      end

      assign data_in = {pe_blk_count{row_skewed}};

      if (pe_blk_count > 1) begin : g_hi
        // Only lane group 0 is consumed in broadcast mode.
        logic unused_act_hi;
        assign unused_act_hi = ^act_data[ACT_W-1:ROW_W];
      end
    end else begin : g_per_blk
      logic [ACT_W-1:0] inject_row;

      assign inject_row = act_accept ? act_data : '0;

      for (genvar b = 0; b < int'(pe_blk_count); b++) begin : g_blk
        for (genvar d = 0; d < int'(systolic_depth); d++) begin : g_lane
          skew_lane_delay #(
            .delay_stages(d + 1),
            .width       (bit_width)
          ) u_dly (
            .clk  (clk),
            .reset(reset),
            .din  (inject_row[b*ROW_W + d*bit_width +: bit_width]),
            .dout (data_in[b*ROW_W + d*bit_width +: bit_width])
          );
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pe_blk_feeder.sv
// tb_pe_blk_feeder
// Directed bench for pe_blk_feeder in broadcast mode (depth 4, 16 columns,
// 16 blocks). Inputs change and outputs are sampled 1 time unit after each
// rising edge, so a value sampled in cycle k reflects the edge ending k-1.
module tb_pe_blk_feeder;
  import pe_blk_feeder_pkg::*;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int C     = 16;
  localparam int B     = 16;
  localparam int WT_W  = W * C * B;
  localparam int ROW_W = W * D;
  localparam int ACT_W = ROW_W * B;

  logic             clk = 1'b0;
  logic             reset;
  logic             wt_valid;
  logic             wt_ready;
  logic [WT_W-1:0]  wt_data;
  logic             act_valid;
  logic             act_ready;
  logic [ACT_W-1:0] act_data;
  logic             act_last;
  logic             is_wt;
  logic [WT_W-1:0]  wt_in;
  logic [ACT_W-1:0] data_in;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pe_blk_feeder #(
    .bit_width      (W),
    .systolic_depth (D),
    .systolic_column(C),
    .pe_blk_count   (B),
    .mode           (3'b100),
    .cnt_width      (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wt_valid (wt_valid),
    .wt_ready (wt_ready),
    .wt_data  (wt_data),
    .act_valid(act_valid),
    .act_ready(act_ready),
    .act_data (act_data),
    .act_last (act_last),
    .is_wt    (is_wt),
    .wt_in    (wt_in),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wt_valid = 1'b0; act_valid = 1'b0; act_last = 1'b0;
    wt_data = '0; act_data = '0;
    tick();
    tick();
    n_checks++; if (is_wt !== 1'b0) $display("FAIL rst_is_wt got %b want 0", is_wt); else n_pass++;
    n_checks++; if (wt_in !== '0) $display("FAIL rst_wt_in got %h want 0 (low 32b)", wt_in[31:0]); else n_pass++;
    n_checks++; if (data_in !== '0) $display("FAIL rst_data_in got %h want 0", data_in); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rst_state got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    n_checks++; if (wt_ready !== 1'b1) $display("FAIL rst_wt_ready got %b want 1", wt_ready); else n_pass++;
    n_checks++; if (act_ready !== 1'b0) $display("FAIL rst_act_ready got %b want 0", act_ready); else n_pass++;
    reset = 1'b0;
  endtask

  // Starts in IDLE; ends in the second STREAM cycle with inputs idle.
  task automatic test_weight_load();
    logic [W-1:0]    kb;
    logic [WT_W-1:0] exp_wt;
    for (int k = 0; k < 4; k++) begin
      kb = W'(k + 1);
      wt_valid = 1'b1; wt_data = {(WT_W/W){kb}};
      act_valid = 1'b1; act_last = 1'b1; act_data = {(ACT_W/8){8'h5A}};
      n_checks++; if (wt_ready !== 1'b1) $display("FAIL wl_wt_ready[%0d] got %b want 1", k, wt_ready); else n_pass++;
      n_checks++; if (act_ready !== 1'b0) $display("FAIL wl_act_ignored[%0d] got act_ready=%b want 0", k, act_ready); else n_pass++;
      n_checks++; if (data_in !== '0) $display("FAIL wl_data_in[%0d] got %h want 0", k, data_in); else n_pass++;
      if (k == 0) begin
        n_checks++; if (is_wt !== 1'b0) $display("FAIL wl_is_wt[0] got %b want 0", is_wt); else n_pass++;
      end else begin
        kb = W'(k);
        exp_wt = {(WT_W/W){kb}};
        n_checks++; if (is_wt !== 1'b1) $display("FAIL wl_is_wt[%0d] got %b want 1", k, is_wt); else n_pass++;
        n_checks++; if (wt_in !== exp_wt) $display("FAIL wl_wt_in[%0d] got %h want %h (low 32b)", k, wt_in[31:0], exp_wt[31:0]); else n_pass++;
      end
      tick();
    end
    // fifth cycle: STREAM; a weight beat offered now must be ignored
    kb = W'(4);
    exp_wt = {(WT_W/W){kb}};
    n_checks++; if (dbg_state !== ST_STREAM) $display("FAIL wl_state got %0d want %0d", dbg_state, ST_STREAM); else n_pass++;
    n_checks++; if (is_wt !== 1'b1) $display("FAIL wl_is_wt[4] got %b want 1", is_wt); else n_pass++;
    n_checks++; if (wt_in !== exp_wt) $display("FAIL wl_wt_in[4] got %h want %h (low 32b)", wt_in[31:0], exp_wt[31:0]); else n_pass++;
    n_checks++; if (data_in !== '0) $display("FAIL wl_data_in[4] got %h want 0", data_in); else n_pass++;
    act_valid = 1'b0; act_last = 1'b0; act_data = '0;
    wt_valid = 1'b1; wt_data = {(WT_W/8){8'hEE}};
    n_checks++; if (wt_ready !== 1'b0) $display("FAIL stream_wt_ready got %b want 0", wt_ready); else n_pass++;
    n_checks++; if (act_ready !== 1'b1) $display("FAIL stream_act_ready got %b want 1", act_ready); else n_pass++;
    tick();
    n_checks++; if (is_wt !== 1'b0) $display("FAIL stream_is_wt got %b want 0", is_wt); else n_pass++;
    n_checks++; if (wt_in !== exp_wt) $display("FAIL stream_wt_in_hold got %h want %h (low 32b)", wt_in[31:0], exp_wt[31:0]); else n_pass++;
    n_checks++; if (dbg_state !== ST_STREAM) $display("FAIL stream_state got %0d want %0d", dbg_state, ST_STREAM); else n_pass++;
    n_checks++; if (data_in !== '0) $display("FAIL stream_data_in got %h want 0", data_in); else n_pass++;
    wt_valid = 1'b0; wt_data = '0;
  endtask

  // Starts in STREAM; single last beat. Ends 6 cycles after the accept.
  task automatic test_skew();
    logic [ROW_W-1:0] exp_slice;
    logic [ACT_W-1:0] exp_data;
    act_valid = 1'b1; act_last = 1'b1;
    act_data = {{((ACT_W-ROW_W)/8){8'hC3}}, 32'h04030201};
    n_checks++; if (act_ready !== 1'b1) $display("FAIL skew_act_ready got %b want 1", act_ready); else n_pass++;
    tick();
    act_valid = 1'b0; act_last = 1'b0; act_data = '0;
    for (int j = 1; j <= 5; j++) begin
      exp_slice = (j <= 4) ? (32'(j) << (8 * (j - 1))) : 32'd0;
      exp_data  = {B{exp_slice}};
      n_checks++; if (data_in !== exp_data) $display("FAIL skew_t%0d got %h want %h", j, data_in, exp_data); else n_pass++;
      if (j == 1) begin
        n_checks++; if (dbg_state !== ST_FLUSH) $display("FAIL skew_state got %0d want %0d", dbg_state, ST_FLUSH); else n_pass++;
        n_checks++; if (act_ready !== 1'b0) $display("FAIL flush_act_ready got %b want 0", act_ready); else n_pass++;
      end
      tick();
    end
  endtask

  // rel = cycles since the last-beat accept at entry.
  task automatic test_flush_done(input int start_rel);
    int rel;
    int bad;
    rel = start_rel;
    bad = 0;
    while (done !== 1'b1 && rel < 60) begin
      if (busy !== 1'b1 || wt_ready !== 1'b0 || act_ready !== 1'b0 ||
          data_in !== '0 || dbg_state !== ST_FLUSH) bad++;
      tick();
      rel++;
    end
    n_checks++; if (rel - 1 != D + C - 1) $display("FAIL flush_zero_cycles got %0d want %0d", rel - 1, D + C - 1); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL flush_outputs got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL done_busy got %b want 1", busy); else n_pass++;
    n_checks++; if (wt_ready !== 1'b0) $display("FAIL done_wt_ready got %b want 0", wt_ready); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL done_width got %b want 0", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL after_done_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (wt_ready !== 1'b1) $display("FAIL after_done_wt_ready got %b want 1", wt_ready); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL after_done_state got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
  endtask

  // Starts in STREAM. Rows A, bubble, B(last); then drains to IDLE.
  task automatic test_bubbles();
    int budget;
    act_valid = 1'b1; act_last = 1'b0;
    act_data = {{(ACT_W-ROW_W){1'b0}}, 32'hA4A3A2A1};
    n_checks++; if (act_ready !== 1'b1) $display("FAIL bub_ready0 got %b want 1", act_ready); else n_pass++;
    tick();
    n_checks++; if (data_in[7:0] !== 8'hA1) $display("FAIL bub_lane0_a got %h want a1", data_in[7:0]); else n_pass++;
    n_checks++; if (data_in[15*ROW_W +: 8] !== 8'hA1) $display("FAIL bub_blk15_lane0_a got %h want a1", data_in[15*ROW_W +: 8]); else n_pass++;
    n_checks++; if (act_ready !== 1'b1) $display("FAIL bub_ready1 got %b want 1", act_ready); else n_pass++;
    act_valid = 1'b0; act_data = '0;
    tick();
    n_checks++; if (data_in[7:0] !== 8'h00) $display("FAIL bub_lane0_zero got %h want 00", data_in[7:0]); else n_pass++;
    n_checks++; if (data_in[15:8] !== 8'hA2) $display("FAIL bub_lane1_a got %h want a2", data_in[15:8]); else n_pass++;
    n_checks++; if (act_ready !== 1'b1) $display("FAIL bub_ready2 got %b want 1", act_ready); else n_pass++;
    act_valid = 1'b1; act_last = 1'b1;
    act_data = {{(ACT_W-ROW_W){1'b0}}, 32'hB4B3B2B1};
    tick();
    act_valid = 1'b0; act_last = 1'b0; act_data = '0;
    n_checks++; if (data_in[7:0] !== 8'hB1) $display("FAIL bub_lane0_b got %h want b1", data_in[7:0]); else n_pass++;
    n_checks++; if (data_in[15:8] !== 8'h00) $display("FAIL bub_lane1_zero got %h want 00", data_in[15:8]); else n_pass++;
    budget = 0;
    while (done !== 1'b1 && budget < 100) begin
      tick();
      budget++;
    end
    n_checks++; if (done !== 1'b1) $display("FAIL bub_drain_done got %b want 1 within 100 cycles", done); else n_pass++;
    tick();
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL bub_idle got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
  endtask

  // Starts in STREAM. Two rows, then reset; ends in IDLE with reset low.
  task automatic test_reset_mid_stream();
    logic [ACT_W-1:0] exp_data;
    act_valid = 1'b1; act_last = 1'b0;
    act_data = {{(ACT_W-ROW_W){1'b0}}, 32'h14131211};
    tick();
    act_data = {{(ACT_W-ROW_W){1'b0}}, 32'h24232221};
    tick();
    act_valid = 1'b0; act_data = '0;
    exp_data = {B{32'h00001221}};
    n_checks++; if (data_in !== exp_data) $display("FAIL mid_pre_reset got %h want %h", data_in, exp_data); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (data_in !== '0) $display("FAIL mid_rst_data_in got %h want 0", data_in); else n_pass++;
    n_checks++; if (is_wt !== 1'b0) $display("FAIL mid_rst_is_wt got %b want 0", is_wt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL mid_rst_done got %b want 0", done); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL mid_rst_state got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_skew();
    test_flush_done(6);
    test_weight_load();
    test_bubbles();
    test_weight_load();
    test_reset_mid_stream();
    test_weight_load();
    test_skew();
    test_flush_done(6);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_blk_feeder.md
Name: pe_blk_feeder

Overview:
- Transmit-side sequencer for the PE block array. Accepts weight rows and activation rows over valid/ready streams.
- Drives the array's is_wt/wt_in weight-load phase, then streams diagonally skewed activations on data_in.
- Finishes with a zero flush so every partial sum drains through the staging memory.
- Sits between the tile buffer/SRAM reader and the PE block array.

Parameters:
- bit_width, 8, element width.
- systolic_depth, 4, rows per PE block (activation lanes, weight rows).
- systolic_column, 16, columns per PE block.
- pe_blk_count, 16, number of PE blocks.
- mode, 3'b100, 3'b100 = broadcast lane group 0 to all blocks; any other value = per-block data.
- cnt_width, 8, width of the phase counters; must satisfy 2^cnt_width > systolic_depth+systolic_column.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wt_valid  in  1  weight row beat valid.
- wt_ready  out  1  weight row accepted when wt_valid&wt_ready.
- wt_data  in  bit_width*systolic_column*pe_blk_count  one weight row for all blocks.
- act_valid  in  1  activation beat valid.
- act_ready  out  1  activation beat accepted when act_valid&act_ready.
- act_data  in  bit_width*systolic_depth*pe_blk_count  one activation row per block; in broadcast mode only bits [bit_width*systolic_depth-1:0] are used.
- act_last  in  1  qualifies the final activation beat; meaningful only with act_valid.
- is_wt  out  1  weight-load strobe to the array.
- wt_in  out  bit_width*systolic_column*pe_blk_count  weight row to the array.
- data_in  out  bit_width*systolic_depth*pe_blk_count  skewed activations to the array.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at the end of FLUSH.

Behaviour:
- Reset (synchronous, active-high; also applies mid-operation): state=IDLE. Outputs is_wt=0, wt_in=0, data_in=0, done=0, busy=0. Skew registers and counters cleared. Any in-flight tile is discarded.
- States: IDLE, LOAD_WT, STREAM, FLUSH.
- IDLE:
  - wt_ready=1, act_ready=0.
  - A wt beat accepted here counts as weight beat 0; next state is LOAD_WT, or STREAM if systolic_depth==1.
- LOAD_WT:
  - wt_ready=1.
  - Each accepted beat increments wt_cnt.
  - After systolic_depth total beats, the next state is STREAM.
  - Row order: first beat feeds the array's deepest row (systolic_depth-1); the last beat feeds row 0.
- Weight output timing:
  - Beat accepted in cycle t gives is_wt=1 and wt_in=wt_data in cycle t+1.
  - If no beat is accepted, is_wt=0 next cycle and wt_in holds its last value.
- STREAM:
  - act_ready=1, wt_ready=0.
  - Every cycle the skew pipeline advances.
  - Accepted beat: row r = act_data is injected.
  - No beat (bubble): an all-zero row is injected.
- Skew rule: lane d (d=0..systolic_depth-1) of each block's row appears on data_in at cycle t+1+d, where t is the injection cycle. Implemented as a triangular register array with lane d delayed d extra stages.
- Broadcast mode (mode==3'b100): lane group 0 is replicated to all pe_blk_count slices of data_in. Otherwise slice b takes act_data slice b.
- Accepted beat with act_last=1: next state is FLUSH with flush_cnt=0.
- FLUSH:
  - Inject zero rows for systolic_depth+systolic_column-1 cycles.
  - Then assert done for exactly 1 cycle and return to IDLE.
  - wt_ready=0 and act_ready=0 throughout.
- Boundaries:
  - act_valid during IDLE/LOAD_WT is ignored (not accepted).
  - wt_valid during STREAM/FLUSH is ignored.
  - A new tile may start the cycle after done, when IDLE accepts a wt beat.
  - Tile length is unbounded; no row counter wraps.
- Arithmetic: no arithmetic on data; counters are cnt_width-bit, compare-equal terminated.

Decomposition:
- Shared package: PE mode localparams (PE_SHARE_NONE..PE_SHARE_ALL), feeder state encoding, and flush-length function (systolic_depth+systolic_column-1).
- One sub-module, skew_lane_delay (parameterised delay line, depth d, width bit_width), instantiated per lane and per block. In broadcast mode only lane group 0 is instantiated and replicated.

Test Plan:
- Weight load: 4 wt beats of value 8'hK in every byte (K=1..4), valid held high from IDLE. Required: is_wt high for 4 consecutive cycles starting 1 cycle after the first accept; wt_in sequence 1,2,3,4; state reaches STREAM on the 5th cycle.
- Skew: single act beat with bytes {8'h04,8'h03,8'h02,8'h01} plus act_last, broadcast mode. Required: data_in lane0=01 at t+1, lane1=02 at t+2, lane2=03 at t+3, lane3=04 at t+4. All 16 block slices are identical; zeros elsewhere.
- Flush/done: after act_last, exactly 19 zero-injection cycles (4+16-1), then a done pulse of 1 cycle with busy falling the cycle after; wt_ready returns to 1.
- Bubbles: act_valid toggling 1,0,1 with rows A, B. Required: lane0 shows A, 0, B on consecutive cycles; act_ready stays 1 in STREAM.
- Backpressure/ignore: wt_valid=1 during STREAM and act_valid=1 during LOAD_WT. Required: wt_ready=0 and act_ready=0 respectively; no change to is_wt or data_in.
- Reset mid-STREAM after 2 rows. Required: next cycle data_in=0, is_wt=0, busy=0, done=0, state IDLE; a subsequent clean tile behaves as in the Weight load and Skew scenarios.
